// File: rtl/shift_sequencer.sv
// shift_sequencer: 32-bit iterative logarithmic shifter (sll/srl/sra), one stage per cycle,
// with start/ready request and done/ack result handshake.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [31:0] work;
  logic [1:0]  op_q;
  logic [4:0]  amt;
  logic [2:0]  cnt;
  logic [4:0]  sh;
  logic signed [31:0] sra_v;
  logic [31:0] stage;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE  ? (start ? (|b[31:5] ? DONE : SHIFT) : IDLE) :
           state == SHIFT ? (cnt == 3'd4 ? DONE : SHIFT) :
                            (ack ? IDLE : DONE);
  always_comb begin
    ready = state == IDLE;
    done  = state == DONE;
  end
  // masking amt with the one-hot stage bit yields either 2^k or 0
  assign sh     = amt & (5'd1 << cnt);
  assign sra_v  = $signed(work) >>> sh;
  assign stage  = op_q == 2'b01 ? work >> sh :
                  op_q == 2'b10 ? sra_v :
                                  work << sh;
  assign result = work;
  always_ff @(posedge clock)
    if (reset) begin
      work <= '0;
      op_q <= '0;
      amt  <= '0;
      cnt  <= '0;
    end else if (state == IDLE && start) begin
      if (|b[31:5]) work <= op == 2'b10 ? {32{a[31]}} : 32'd0;
      else begin
        work <= a;
        op_q <= op;
        amt  <= b[4:0];
        cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      work <= stage;
      cnt  <= cnt + 3'd1;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;
  logic        clock = 0, reset = 0, start = 0, ack = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        ready, done;
  logic [31:0] result;
  int checks = 0, errors = 0;

  shift_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .ack(ack), .ready(ready), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (!done && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic retire(input string tag, input logic [31:0] exp);
    @(negedge clock); ack = 1;
    @(posedge clock); #1 ack = 0;
    chk({tag, "_ready"}, {31'd0, ready}, 1);
    chk({tag, "_done_low"}, {31'd0, done}, 0);
    chk({tag, "_hold"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] exp);
    @(negedge clock); op = o; a = av; b = bv; start = 1;
    @(posedge clock); #1 start = 0;
    chk({tag, "_busy"}, {31'd0, ready}, 0);
    wait_done(tag, lat);
    chk(tag, result, exp);
    retire(tag, exp);
  endtask

  initial begin
    // reset wins over a simultaneous start
    reset = 1; start = 1; op = 0; a = 32'h1; b = 32'h1;
    repeat (2) @(posedge clock);
    #1 reset = 0; start = 0;
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", result, 0);

    run_op("sll_1_4",      2'b00, 32'h00000001, 32'd4,     5, 32'h00000010);
    run_op("sra_min_31",   2'b10, 32'h80000000, 32'd31,    5, 32'hFFFFFFFF);
    run_op("srl_min_31",   2'b01, 32'h80000000, 32'd31,    5, 32'h00000001);
    run_op("sll_amt0",     2'b00, 32'hDEADBEEF, 32'd0,     5, 32'hDEADBEEF);
    run_op("srl_oor_32",   2'b01, 32'hFFFFFFFF, 32'd32,    0, 32'h00000000);
    run_op("sra_oor_neg",  2'b10, 32'h80000000, 32'h100,   0, 32'hFFFFFFFF);
    run_op("sra_oor_pos",  2'b10, 32'h7FFFFFFF, 32'h40,    0, 32'h00000000);
    run_op("op11_sll",     2'b11, 32'h00000001, 32'd3,     5, 32'h00000008);
    run_op("sra_f0_4",     2'b10, 32'hF0000000, 32'd4,     5, 32'hFF000000);
    run_op("srl_mixed_12", 2'b01, 32'h12345678, 32'd12,    5, 32'h00012345);
    run_op("sll_mixed_21", 2'b00, 32'h12345678, 32'd21,    5, 32'hCF000000);

    // start held high through SHIFT and DONE with changed operands, ack delayed
    @(negedge clock); op = 2'b00; a = 32'h1; b = 32'd4; start = 1;
    @(posedge clock); #1 op = 2'b01; a = 32'h00000F00; b = 32'd8;
    wait_done("hold_first", 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("hold_done", {31'd0, done}, 1);
      chk("hold_result", result, 32'h10);
    end
    @(negedge clock); ack = 1;
    @(posedge clock); #1 ack = 0;
    chk("ack_start_ready", {31'd0, ready}, 1);
    chk("ack_start_result", result, 32'h10);
    @(posedge clock); #1 start = 0;
    chk("second_accept", {31'd0, ready}, 0);
    wait_done("second", 5);
    chk("second_result", result, 32'h0000000F);
    retire("second", 32'h0000000F);

    // ack in SHIFT is ignored
    @(negedge clock); op = 2'b00; a = 32'h3; b = 32'd2; start = 1;
    @(posedge clock); #1 start = 0; ack = 1;
    @(posedge clock); #1 ack = 0;
    wait_done("ack_in_shift", 4);
    chk("ack_in_shift_result", result, 32'hC);
    retire("ack_in_shift", 32'hC);

    // reset on the third SHIFT edge aborts with no done pulse
    @(negedge clock); op = 2'b00; a = 32'h5; b = 32'd7; start = 1;
    @(posedge clock); #1 start = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_result", result, 0);
    chk("abort_ready", {31'd0, ready}, 1);
    repeat (6) @(posedge clock);
    #1 chk("abort_no_done", {31'd0, done}, 0);
    run_op("post_abort", 2'b00, 32'h3, 32'd1, 5, 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
